div_iter: RTL
=============

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have port clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_in  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port dividend  input  XLEN  unsigned dividend, already magnitude-converted by the EX stage.
REQ-005 SHALL have port divisor  input  XLEN  unsigned divisor, already magnitude-converted by the EX stage.
REQ-006 SHALL have port req_in  input  1  request, level; held high with stable operands until ready_out.
REQ-007 SHALL have port is_q_in  input  1  1 = return quotient, 0 = return remainder.
REQ-008 SHALL have port ready_out  output  1  result valid; one-cycle pulse.
REQ-009 SHALL have port result_out  output  XLEN  quotient or remainder per latched is_q.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-011 IDLE with req_in=1 SHALL latch dividend, divisor and is_q_in, clear the remainder accumulator and iteration counter, and go to BUSY.
REQ-012 IDLE with req_in=0 SHALL stay in IDLE with ready_out=0.
REQ-013 BUSY SHALL perform one restoring shift-subtract step per cycle, MSB first: rem = {rem[XLEN-2:0], dvd[msb]}; if rem >= divisor then rem -= divisor and quotient bit = 1, else 0.
REQ-014 BUSY SHALL run exactly XLEN steps; the 6-bit counter SHALL run 0..XLEN-1 and go to DONE after step XLEN-1.
REQ-015 Latency: ready_out SHALL be high in the cycle beginning XLEN+1 rising edges after the accepting edge (33 for XLEN=32).
REQ-016 DONE SHALL assert ready_out=1 for exactly one cycle, drive the final result, and go to IDLE on the next edge.
REQ-017 ready_out SHALL be 0 in IDLE and BUSY.
REQ-018 If req_in is still high in IDLE after DONE, a new operation SHALL start with no bubble beyond the IDLE cycle; back-to-back requests are allowed.
REQ-019 If req_in falls during BUSY, the FSM SHALL abort to IDLE on the next edge, ready_out SHALL stay 0, and result_out SHALL keep its previous value.
REQ-020 divisor=0 SHALL yield quotient all-ones (2^XLEN-1) and remainder = dividend, which is the natural restoring result, with no special case required.
REQ-021 result_out SHALL be quotient when latched is_q=1, otherwise remainder.
REQ-022 result_out SHALL hold its value from DONE until the next DONE.
REQ-023 Operand changes on the inputs after acceptance SHALL NOT affect the running operation.
REQ-024 No combinational path SHALL exist from any input to ready_out or result_out.

Reset
REQ-025 With reset_in=0 at a rising edge, the FSM SHALL go to IDLE, and ready_out, result_out, the counter and all datapath registers SHALL be 0.
REQ-026 Reset SHALL take priority over every other event, including mid-BUSY and the DONE cycle; no ready_out pulse SHALL follow a reset until a new request is accepted.

Configuration
REQ-027 Macro DIV_ITER_EARLY_OUT_EN, when defined: at acceptance, if divisor=0 or dividend<divisor, the FSM SHALL go directly to DONE, ready_out SHALL assert 1 cycle after the accepting edge, and results SHALL be per REQ-020, or quotient 0 and remainder = dividend.
REQ-028 Macro undefined: every operation SHALL take the full REQ-015 latency.
REQ-029 Results SHALL be bit-identical with or without the macro.

Verification
REQ-030 dividend=100, divisor=7, is_q=1, req held -> ready_out pulses once at cycle 33; result_out=14.
REQ-031 dividend=100, divisor=7, is_q=0 -> result_out=2. Then, with req held high, dividend=0xFFFFFFFF, divisor=1, is_q=1 -> second pulse 34 cycles after the first; result_out=0xFFFFFFFF.
REQ-032 divisor=0, dividend=0x1234, run once with is_q=1 and once with is_q=0 -> results 0xFFFFFFFF and 0x1234; latency 1 cycle with DIV_ITER_EARLY_OUT_EN defined, 33 without.
REQ-033 dividend=5, divisor=9, is_q=1 -> quotient 0; with is_q=0 -> remainder 5; latency per REQ-027/REQ-028.
REQ-034 Start 100/7, drop req_in at BUSY step 10 -> no ready_out pulse; result_out unchanged; FSM in IDLE.
REQ-035 Assert reset_in=0 at BUSY step 20 of 100/7, release, issue 50/5 -> all outputs 0 during reset; single pulse with result_out=10, 33 cycles after acceptance.

Source files
------------

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// Optional DIV_ITER_EARLY_OUT_EN skips the iteration when divisor=0 or dividend<divisor.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            req_in,
  input  logic            is_q_in,
  output logic            ready_out,
  output logic [XLEN-1:0] result_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] LAST_STEP = 6'(XLEN - 1);

  state_t          state;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dsr;
  logic [XLEN-1:0] rem;
  logic [5:0]      cnt;
  logic            is_q;

  logic [XLEN:0]   rem_shift;
  logic [XLEN-1:0] rem_diff;
  logic            q_bit;

  // The shifted partial remainder keeps one extra bit so divisors above 2^(XLEN-1) still compare correctly.
  always_comb begin
    rem_shift = {rem, dvd[XLEN-1]};
    q_bit     = (rem_shift >= {1'b0, dsr});
    rem_diff  = rem_shift[XLEN-1:0] - dsr;
  end

`ifdef DIV_ITER_EARLY_OUT_EN
  logic early;
  assign early = (divisor == '0) || (dividend < divisor);
`endif

  // dvd doubles as the quotient register: dividend bits shift out the top while quotient bits shift in below.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state      <= IDLE;
      dvd        <= '0;
      dsr        <= '0;
      rem        <= '0;
      cnt        <= '0;
      is_q       <= 1'b0;
      ready_out  <= 1'b0;
      result_out <= '0;
    end else begin
      ready_out <= 1'b0;
      case (state)
        IDLE: begin
          if (req_in) begin
            dvd   <= dividend;
            dsr   <= divisor;
            is_q  <= is_q_in;
            rem   <= '0;
            cnt   <= '0;
            state <= BUSY;
`ifdef DIV_ITER_EARLY_OUT_EN
            if (early) begin
              dvd   <= (divisor == '0) ? '1 : '0;
              rem   <= dividend;
              state <= DONE;
            end
`endif
          end
        end
        BUSY: begin
          if (!req_in) begin
            state <= IDLE;
          end else begin
            rem <= q_bit ? rem_diff : rem_shift[XLEN-1:0];
            dvd <= {dvd[XLEN-2:0], q_bit};
            cnt <= cnt + 6'd1;
            if (cnt == LAST_STEP) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          ready_out  <= 1'b1;
          result_out <= is_q ? dvd : rem;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
